// File: rtl/rib_arb_pkg.sv
// rib_arb_pkg: shared encodings for the RIB bus arbiter.
// Holds the FSM state type, the master index constants and the priority mode constants.
package rib_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
    localparam logic [1:0] RIB_M_CORE_EX = 2'd0;
    localparam logic [1:0] RIB_M_CORE_PC = 2'd1;
    localparam logic [1:0] RIB_M_JTAG    = 2'd2;
    localparam logic [1:0] RIB_M_UART    = 2'd3;
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;
endpackage

// File: rtl/rib_arb_pick.sv
// rib_arb_pick: combinational winner picker, fixed (m3 > m2 > m0 > m1) or rotating from start.
// Ports: req - per-master requests; start - first index searched in round-robin mode;
//        mode - ARB_FIXED / ARB_RR; gnt_onehot / gnt_idx - winner; any - some request present.
module rib_arb_pick
    import rib_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    input  logic       mode,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_rr_idx;
    logic [1:0] w_fix_idx;

    always_comb begin
        // w_rot[i] is the request of master start+i (mod 4), so the lowest set bit is the RR winner
        w_rot = '0;
        for (int i = 0; i < 4; i++) w_rot[i] = req[2'(start + 2'(i))];
        w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
        w_rr_idx = start + w_off;
        w_fix_idx = req[RIB_M_UART]    ? RIB_M_UART    :
                    req[RIB_M_JTAG]    ? RIB_M_JTAG    :
                    req[RIB_M_CORE_EX] ? RIB_M_CORE_EX :
                    req[RIB_M_CORE_PC] ? RIB_M_CORE_PC : RIB_M_CORE_EX;
        gnt_idx = (mode == ARB_RR) ? w_rr_idx : w_fix_idx;
        any = |req;
        gnt_onehot = any ? (4'b0001 << gnt_idx) : 4'b0000;
    end
endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: IDLE/BUSY arbiter sharing the RIB slave fabric between four masters.
// Ports: clk, rst (sync, active-low); req_i per-master requests; ack_i slave acknowledge;
//        prio_mode_i fixed/RR select; grant_o/grant_idx_o/busy_o registered grant;
//        ack_o per-master acknowledge; err_o/timeout_o forced-release flags; hold_flag_o core hold.
module rib_arbiter
    import rib_arb_pkg::*;
#(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       ack_i,
    input  logic       prio_mode_i,
    output logic [3:0] grant_o,
    output logic [1:0] grant_idx_o,
    output logic       busy_o,
    output logic [3:0] ack_o,
    output logic       err_o,
    output logic       timeout_o,
    output logic       hold_flag_o
);
    arb_state_e           r_state, w_state_nx;
    logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]           r_last, w_last_nx, w_idx_nx, w_pick_idx, w_start;
    logic [3:0]           w_grant_nx, w_pick_oh;
    logic                 w_busy_nx, w_pick_any, w_busy_st, w_ack, w_abort, w_to;

    assign w_start = r_last + 2'd1;

    rib_arb_pick u_pick (
        .req        (req_i),
        .start      (w_start),
        .mode       (prio_mode_i),
        .gnt_onehot (w_pick_oh),
        .gnt_idx    (w_pick_idx),
        .any        (w_pick_any)
    );

    always_comb begin
        w_busy_st = r_state == ARB_BUSY;
        // ack wins over abort, abort wins over timeout
        w_ack = w_busy_st && ack_i;
        w_abort = w_busy_st && !ack_i && !req_i[grant_idx_o];
        w_to = w_busy_st && !ack_i && req_i[grant_idx_o] &&
               r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
        ack_o = (w_ack || w_to) ? grant_o : 4'b0000;
        err_o = w_to;
        timeout_o = w_to;
        // grant_idx_o[1] selects the debug/download masters m2 and m3
        hold_flag_o = (w_busy_st && grant_idx_o[1]) ||
                      (req_i[RIB_M_CORE_EX] && !(w_busy_st && grant_idx_o == RIB_M_CORE_EX));
        w_state_nx = r_state;
        w_grant_nx = grant_o;
        w_idx_nx = grant_idx_o;
        w_busy_nx = busy_o;
        w_cnt_nx = r_cnt;
        w_last_nx = r_last;
        if (r_state == ARB_IDLE) begin
            if (w_pick_any) begin
                w_state_nx = ARB_BUSY;
                w_grant_nx = w_pick_oh;
                w_idx_nx = w_pick_idx;
                w_busy_nx = 1'b1;
                w_cnt_nx = '0;
            end
        end else if (w_ack || w_to || w_abort) begin
            w_state_nx = ARB_IDLE;
            w_grant_nx = 4'b0000;
            w_idx_nx = 2'd0;
            w_busy_nx = 1'b0;
            w_cnt_nx = '0;
            w_last_nx = w_abort ? r_last : grant_idx_o;
        end else begin
            w_cnt_nx = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            grant_o <= 4'b0000;
            grant_idx_o <= 2'd0;
            busy_o <= 1'b0;
            r_cnt <= '0;
            r_last <= 2'd3;
        end else begin
            r_state <= w_state_nx;
            grant_o <= w_grant_nx;
            grant_idx_o <= w_idx_nx;
            busy_o <= w_busy_nx;
            r_cnt <= w_cnt_nx;
            r_last <= w_last_nx;
        end
    end
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rib_arbiter;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_i = 4'b0000;
    logic       ack_i = 1'b0;
    logic       prio_mode_i = 1'b0;
    logic [3:0] grant_o, ack_o;
    logic [1:0] grant_idx_o;
    logic       busy_o, err_o, timeout_o, hold_flag_o;

    int n_checks = 0;
    int n_fail = 0;

    rib_arbiter #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .prio_mode_i (prio_mode_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .timeout_o   (timeout_o),
        .hold_flag_o (hold_flag_o)
    );

    always #5 clk = ~clk;

    // one cycle: inputs change just after the rising edge, outputs are observed at the falling edge
    task automatic apply(input logic [3:0] r, input logic a, input logic m, input logic rs);
        @(posedge clk);
        #1;
        req_i = r;
        ack_i = a;
        prio_mode_i = m;
        rst = rs;
        @(negedge clk);
    endtask

    function automatic logic [1:0] winner(input logic [3:0] r, input logic m, input logic [1:0] last);
        int order[4];
        order[0] = 3; order[1] = 2; order[2] = 0; order[3] = 1;
        if (m) begin
            for (int k = 1; k <= 4; k++)
                if (r[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
        end else begin
            for (int k = 0; k < 4; k++)
                if (r[order[k]]) return 2'(order[k]);
        end
        return 2'd0;
    endfunction

    task automatic test_reset();
        apply(4'b1111, 1'b0, 1'b0, 1'b0);
        apply(4'b1111, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o} !== 14'b0000_00_0_0000_0_0_1) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b",
                     {grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o}, 14'b0000_00_0_0000_0_0_1);
        end
    endtask

    task automatic test_fixed_first();
        apply(4'b1111, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o} !== 14'b0000_00_0_0000_0_0_1) begin
            n_fail++;
            $display("FAIL first_idle: got %b want %b",
                     {grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o}, 14'b0000_00_0_0000_0_0_1);
        end
        apply(4'b1111, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o} !== 14'b1000_11_1_1000_0_0_1) begin
            n_fail++;
            $display("FAIL first_grant_m3: got %b want %b",
                     {grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o}, 14'b1000_11_1_1000_0_0_1);
        end
        apply(4'b0000, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({grant_o, busy_o, ack_o} !== 9'b0000_0_0000) begin
            n_fail++;
            $display("FAIL first_release: got %b want %b", {grant_o, busy_o, ack_o}, 9'b0000_0_0000);
        end
    endtask

    task automatic test_rr_cycle();
        logic [3:0] exp_g;
        apply(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            apply(4'b1111, 1'b1, 1'b1, 1'b1);
            exp_g = (k % 2 == 1) ? 4'(1 << ((k / 2) % 4)) : 4'b0000;
            n_checks++;
            if ({grant_o, ack_o} !== {exp_g, exp_g}) begin
                n_fail++;
                $display("FAIL rr_cycle[%0d]: grant/ack got %b/%b want %b/%b", k, grant_o, ack_o, exp_g, exp_g);
            end
        end
    endtask

    task automatic test_fixed_starve();
        logic [3:0] exp_g;
        apply(4'b0011, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            apply(4'b0011, 1'b1, 1'b0, 1'b1);
            exp_g = (k % 2 == 1) ? 4'b0001 : 4'b0000;
            n_checks++;
            if ({grant_o, hold_flag_o} !== {exp_g, k % 2 == 0}) begin
                n_fail++;
                $display("FAIL fixed_starve[%0d]: grant/hold got %b/%b want %b/%b",
                         k, grant_o, hold_flag_o, exp_g, k % 2 == 0);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_g, exp_a;
        logic       exp_t;
        apply(4'b0100, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            apply(4'b0100, 1'b0, 1'b0, 1'b1);
            exp_g = ((k >= 1 && k <= TO) || k == TO + 2) ? 4'b0100 : 4'b0000;
            exp_t = (k == TO);
            exp_a = exp_t ? 4'b0100 : 4'b0000;
            n_checks++;
            if ({grant_o, ack_o, err_o, timeout_o} !== {exp_g, exp_a, exp_t, exp_t}) begin
                n_fail++;
                $display("FAIL timeout[%0d]: grant/ack/err/to got %b/%b/%b/%b want %b/%b/%b/%b",
                         k, grant_o, ack_o, err_o, timeout_o, exp_g, exp_a, exp_t, exp_t);
            end
        end
    endtask

    task automatic test_abort();
        apply(4'b0010, 1'b0, 1'b1, 1'b0);
        apply(4'b0010, 1'b0, 1'b1, 1'b1);
        apply(4'b0010, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({grant_o, ack_o} !== 8'b0010_0010) begin
            n_fail++;
            $display("FAIL abort_setup_m1: grant/ack got %b/%b want 0010/0010", grant_o, ack_o);
        end
        apply(4'b1000, 1'b0, 1'b1, 1'b1);
        apply(4'b1000, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (grant_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL abort_grant_m3: got %b want 1000", grant_o);
        end
        apply(4'b0000, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({ack_o, err_o, timeout_o} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL abort_no_ack: got %b want 000000", {ack_o, err_o, timeout_o});
        end
        apply(4'b1111, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({grant_o, busy_o} !== 5'b0000_0) begin
            n_fail++;
            $display("FAIL abort_idle: grant/busy got %b/%b want 0000/0", grant_o, busy_o);
        end
        apply(4'b1111, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_pointer_kept: got %b want 0100", grant_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        apply(4'b0001, 1'b0, 1'b0, 1'b0);
        apply(4'b0001, 1'b0, 1'b0, 1'b1);
        apply(4'b0001, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (grant_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_grant: got %b want 0001", grant_o);
        end
        apply(4'b0001, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ack_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_ack: got %b want 0001", ack_o);
        end
        apply(4'b0001, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o} !== 14'b0000_00_0_0000_0_0_1) begin
            n_fail++;
            $display("FAIL midrst_after: got %b want %b",
                     {grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o}, 14'b0000_00_0_0000_0_0_1);
        end
    endtask

    task automatic test_random();
        bit         m_busy = 1'b0;
        logic [1:0] m_idx = 2'd0;
        logic [1:0] m_last = 2'd3;
        int         m_age = 0;
        logic [3:0] r, oh, e_ack;
        logic       a, m, rs, acked, aborted, timed, e_hold;
        logic [13:0] exp_v, got_v;
        apply(4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            r = 4'($urandom);
            if (m_busy && $urandom_range(4) != 0) r[m_idx] = 1'b1;
            a = ($urandom_range(3) == 0);
            m = 1'($urandom);
            rs = ($urandom_range(80) != 0);
            apply(r, a, m, rs);
            oh = m_busy ? 4'(1 << m_idx) : 4'b0000;
            acked = m_busy && a;
            aborted = m_busy && !a && !r[m_idx];
            timed = m_busy && !a && r[m_idx] && m_age == TO;
            e_ack = (acked || timed) ? oh : 4'b0000;
            e_hold = (m_busy && m_idx >= 2) || (r[0] && !(m_busy && m_idx == 0));
            exp_v = {oh, m_busy ? m_idx : 2'd0, m_busy, e_ack, timed, timed, e_hold};
            got_v = {grant_o, grant_idx_o, busy_o, ack_o, err_o, timeout_o, hold_flag_o};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] req=%b ack=%b mode=%b rst=%b: got %b want %b",
                         i, r, a, m, rs, got_v, exp_v);
            end
            if (!rs) begin
                m_busy = 1'b0; m_idx = 2'd0; m_age = 0; m_last = 2'd3;
            end else if (!m_busy) begin
                if (r != 4'b0000) begin
                    m_idx = winner(r, m, m_last); m_busy = 1'b1; m_age = 1;
                end
            end else if (acked || timed) begin
                m_last = m_idx; m_busy = 1'b0; m_idx = 2'd0;
            end else if (aborted) begin
                m_busy = 1'b0; m_idx = 2'd0;
            end else begin
                m_age++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_first();
        test_rr_cycle();
        test_fixed_starve();
        test_timeout();
        test_abort();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
